// File: rtl/shift_seq_ctl.sv
// Sequencer for an external falling-edge universal shift register: parallel-load/shift-out
// transmit, and clear/shift-in/parallel-read receive.
module shift_seq_ctl #(
    parameter int   W    = 4,
    parameter logic FILL = 1'b0
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         start,
    input  logic         mode,
    input  logic [W-1:0] din,
    input  logic         ser_in,
    input  logic         ser_valid,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] dout,
    output logic         ser_out,
    output logic         ser_strobe,
    output logic         sr_clr_n,
    output logic         sr_ldsh,
    output logic         sr_ser,
    output logic [W-1:0] sr_in,
    output logic         sr_oe_n,
    output logic         sr_clken,
    input  logic [W-1:0] sr_q,
    input  logic         sr_qd
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);
    localparam logic [CW-1:0] FULL = CW'(W);

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, SHIFT, READ, DONE} state_t;

    state_t        state, state_nx;
    logic          rx, rx_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [W-1:0]  sr_in_nx, dout_nx;
    logic          sr_ser_nx, sr_clken_nx, sr_ldsh_nx, sr_clr_n_nx, sr_oe_n_nx;
    logic          busy_nx, done_nx;

    // Register-side outputs are computed for the cycle being entered and registered
    // with the state, so each cycle's falling-edge register action matches its state.
    always_comb begin
        state_nx    = state;
        rx_nx       = rx;
        cnt_nx      = cnt;
        sr_in_nx    = sr_in;
        dout_nx     = dout;
        sr_ser_nx   = 1'b0;
        sr_clken_nx = 1'b0;
        sr_ldsh_nx  = 1'b0;
        sr_clr_n_nx = 1'b1;
        sr_oe_n_nx  = 1'b1;
        case (state)
            IDLE: begin
                if (start) begin
                    rx_nx = mode;
                    if (mode) begin
                        state_nx    = CLEAR;
                        sr_clr_n_nx = 1'b0;
                    end else begin
                        state_nx    = LOAD;
                        sr_in_nx    = din;
                        sr_ldsh_nx  = 1'b1;
                        sr_clken_nx = 1'b1;
                    end
                end
            end
            LOAD: begin
                state_nx    = SHIFT;
                cnt_nx      = '0;
                sr_ser_nx   = FILL;
                sr_clken_nx = 1'b1;
            end
            CLEAR: begin
                state_nx = SHIFT;
                cnt_nx   = '0;
            end
            SHIFT: begin
                if (!rx) begin
                    cnt_nx = cnt + 1'b1;
                    if (cnt == LAST) begin
                        state_nx = DONE;
                    end else begin
                        sr_ser_nx   = FILL;
                        sr_clken_nx = 1'b1;
                    end
                // A bit sampled here is shifted during the next cycle, so the W-th
                // bit's shift happens in the final SHIFT cycle (cnt == W).
                end else if (cnt == FULL) begin
                    state_nx   = READ;
                    sr_oe_n_nx = 1'b0;
                end else begin
                    sr_ser_nx   = ser_in;
                    sr_clken_nx = ser_valid;
                    if (ser_valid) cnt_nx = cnt + 1'b1;
                end
            end
            READ: begin
                state_nx = DONE;
                dout_nx  = sr_q;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx != IDLE);
        done_nx = (state_nx == DONE);
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state    <= IDLE;
            rx       <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dout     <= '0;
            sr_clr_n <= 1'b0;
            sr_ldsh  <= 1'b0;
            sr_ser   <= 1'b0;
            sr_in    <= '0;
            sr_oe_n  <= 1'b1;
            sr_clken <= 1'b0;
        end else begin
            state    <= state_nx;
            rx       <= rx_nx;
            cnt      <= cnt_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            dout     <= dout_nx;
            sr_clr_n <= sr_clr_n_nx;
            sr_ldsh  <= sr_ldsh_nx;
            sr_ser   <= sr_ser_nx;
            sr_in    <= sr_in_nx;
            sr_oe_n  <= sr_oe_n_nx;
            sr_clken <= sr_clken_nx;
        end
    end

    assign ser_out    = sr_qd;
    assign ser_strobe = (state == SHIFT) && !rx;

endmodule

// File: tb/tb_shift_seq_ctl.sv
// Bench for shift_seq_ctl: drives random transmit/receive operations against a
// behavioural falling-edge shift register and checks framing, bit order and reset.
module tb_shift_seq_ctl;

    localparam int W = 4;

    logic         clk, clr, start, mode, ser_in, ser_valid;
    logic [W-1:0] din, dout, sr_in, sr_q;
    logic         busy, done, ser_out, ser_strobe;
    logic         sr_clr_n, sr_ldsh, sr_ser, sr_oe_n, sr_clken, sr_qd;

    shift_seq_ctl #(.W(W), .FILL(1'b0)) dut (
        .clk(clk), .clr(clr), .start(start), .mode(mode), .din(din),
        .ser_in(ser_in), .ser_valid(ser_valid), .busy(busy), .done(done),
        .dout(dout), .ser_out(ser_out), .ser_strobe(ser_strobe),
        .sr_clr_n(sr_clr_n), .sr_ldsh(sr_ldsh), .sr_ser(sr_ser), .sr_in(sr_in),
        .sr_oe_n(sr_oe_n), .sr_clken(sr_clken), .sr_q(sr_q), .sr_qd(sr_qd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External register: acts on the falling edge, shifts toward the MSB.
    logic [W-1:0] sreg = '0;
    always @(negedge clk) begin
        if (!sr_clr_n)     sreg <= '0;
        else if (sr_clken) sreg <= sr_ldsh ? sr_in : {sreg[W-2:0], sr_ser};
    end
    assign sr_q  = sr_oe_n ? '0 : sreg;
    assign sr_qd = sreg[W-1];

    int n_tests = 0;
    int n_fail  = 0;
    int done_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Per-cycle monitor: control exclusivity, done counting, dout only updates after READ.
    logic [W-1:0] dout_prev = '0;
    logic         prev_oe_low = 1'b0;
    logic         clr_prev = 1'b0;
    always @(negedge clk) begin
        check("excl", 32'(int'(!sr_clr_n) + int'(sr_ldsh) + int'(!sr_oe_n) <= 1), 1);
        if (done) done_total++;
        if (dout !== dout_prev && clr_prev) check("dout_when", prev_oe_low, 1);
        dout_prev   = dout;
        prev_oe_low = !sr_oe_n;
        clr_prev    = clr;
    end

    task automatic check_reset(input string tag);
        check(tag, {busy, done, ser_strobe, sr_clr_n, sr_ldsh, sr_ser, sr_oe_n, sr_clken},
              8'b0000_0010);
        check({tag, "_dout"}, dout, 0);
        check({tag, "_in"}, sr_in, 0);
    endtask

    task automatic do_reset();
        clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_reset("rst");
        clr = 1'b1;
        @(posedge clk);
        #1 check("rst_release", {sr_clr_n, busy}, 2'b10);
    endtask

    task automatic finish_op(input string tag, input bit noisy, input int done_before);
        start = noisy;
        mode  = 1'($urandom);
        @(posedge clk);
        #1 start = 1'b0;
        check({tag, "_idle"}, busy, 0);
        @(posedge clk);
        #1 check({tag, "_idle2"}, busy, 0);
        check({tag, "_ndone"}, done_total - done_before, 1);
    endtask

    task automatic run_tx(input logic [W-1:0] d, input bit noisy);
        int strobes = 0;
        int done_before = done_total;
        bit fin = 0;
        logic [W-1:0] got = '0;
        start = 1'b1; mode = 1'b0; din = d;
        for (int k = 1; k <= 40 && !fin; k++) begin
            @(posedge clk);
            #1;
            start = noisy ? 1'($urandom) : 1'b0;
            mode  = 1'($urandom);
            din   = W'($urandom);
            check("tx_busy", busy, 1);
            if (k == 1) check("tx_load", {sr_ldsh, sr_clken, sr_in}, {2'b11, d});
            if (ser_strobe) begin
                if (strobes < W) got[W-1-strobes] = ser_out;
                strobes++;
            end
            if (done) begin
                check("tx_done_cyc", k, W + 2);
                fin = 1;
            end
        end
        check("tx_fin", fin, 1);
        check("tx_strobes", strobes, W);
        check("tx_bits", got, d);
        finish_op("tx", noisy, done_before);
    endtask

    task automatic run_rx(input logic [W-1:0] bits, input int max_gap, input bit noisy);
        int idx = 0, gap = 0, reads = 0, shifts = 0;
        int done_before = done_total;
        bit fin = 0;
        start = 1'b1; mode = 1'b1; din = W'($urandom); ser_valid = 1'b0;
        gap = $urandom_range(0, max_gap);
        for (int k = 1; k <= 200 && !fin; k++) begin
            @(posedge clk);
            #1;
            start = noisy ? 1'($urandom) : 1'b0;
            mode  = 1'($urandom);
            check("rx_busy", busy, 1);
            check("rx_strobe", ser_strobe, 0);
            if (k == 1) check("rx_clear", {sr_clr_n, sr_clken}, 2'b00);
            if (!sr_oe_n) reads++;
            if (sr_clken) shifts++;
            if (done) fin = 1;
            ser_valid = 1'b0;
            ser_in    = 1'($urandom);
            if (k >= 2 && idx < W) begin
                if (gap > 0) gap--;
                else begin
                    ser_valid = 1'b1;
                    ser_in    = bits[W-1-idx];
                    idx++;
                    gap = $urandom_range(0, max_gap);
                end
            end
        end
        ser_valid = 1'b0;
        check("rx_fin", fin, 1);
        check("rx_reads", reads, 1);
        check("rx_shifts", shifts, W);
        check("rx_dout", dout, bits);
        finish_op("rx", noisy, done_before);
    endtask

    task automatic run_abort(input logic [W-1:0] d);
        int done_before = done_total;
        start = 1'b1; mode = 1'b0; din = d;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1 start = 1'b0;
            if (k == 4) check("ab_strobe", ser_strobe, 1);
        end
        clr = 1'b0;
        @(posedge clk);
        #1 check_reset("ab_rst");
        clr = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("ab_busy", busy, 0);
        check("ab_nodone", done_total - done_before, 0);
    endtask

    initial begin
        clr = 1'b0; start = 1'b0; mode = 1'b0; din = '0; ser_in = 1'b0; ser_valid = 1'b0;
        do_reset();
        run_tx(4'b1011, 1'b0);
        run_rx(4'b1101, 0, 1'b0);
        run_rx(4'b1101, 3, 1'b0);
        run_tx(4'b0110, 1'b1);
        run_rx(4'b1001, 2, 1'b1);
        run_abort(4'b1110);
        run_tx(4'b1110, 1'b0);
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 1) == 0) run_tx(W'($urandom), 1'($urandom));
            else run_rx(W'($urandom), $urandom_range(0, 3), 1'($urandom));
        end
        run_rx(4'b0000, 1, 1'b0);
        run_tx(4'b1111, 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
